pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side companion to the servo PWM generator. Measures high time and
//  period of an external PWM line (servo/RC input, or loopback of our own
//  generator) in clk cycles. Publishes one width/period pair per complete cycle,
//  with a range check and a dead-line timeout. Sits between the pad and the
//  position-decode logic.
// PARAMETERS
//  CNT_W    32       width of counters and of the width/period outputs
//  TIMEOUT  4000000  cycles without an expected edge before the line is declared
//                    dead; must be < 2**CNT_W and > largest expected period
//  MIN_W    50000    minimum legal high time (cycles), inclusive
//  MAX_W    250000   maximum legal high time (cycles), inclusive
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-high
//  pwm_in    in   1      asynchronous PWM line
//  width     out  CNT_W  last measured high time, cycles
//  period    out  CNT_W  last measured rise-to-rise period, cycles
//  valid     out  1      one-cycle strobe: width/period/in_range just updated
//  in_range  out  1      MIN_W <= width <= MAX_W, updated with valid
//  timeout   out  1      sticky: line dead; cleared by next valid
//  active    out  1      high when FSM is in HIGH or LOW
// BEHAVIOUR
//  Reset: width=0, period=0, valid=0, in_range=0, timeout=0, active=0,
//   FSM=IDLE, counters=0. Sync flops and edge-history flop reset to 1, so a line
//   already high at reset release is not taken as a rising edge.
//  Input: 2-flop synchronizer then edge-history flop. rise = s2 & ~prev,
//   fall = ~s2 & prev. Edge actions occur on the 3rd clk edge after pwm_in
//   changes (setup met).
//  Counting: on rise, cnt <= 1; otherwise cnt <= cnt+1 in HIGH/LOW.
//   Result: a line high H cycles with period P reads width=H, period=P exactly.
//  FSM:
//   IDLE: wait for rise. rise -> HIGH, cnt<=1. Nothing published.
//   HIGH: fall -> hi_lat <= cnt, go LOW. cnt==TIMEOUT -> go IDLE, timeout<=1.
//   LOW : rise -> width<=hi_lat, period<=cnt, in_range<=range(hi_lat),
//         valid<=1, timeout<=0, cnt<=1, go HIGH (no gap between measurements).
//         cnt==TIMEOUT -> go IDLE, timeout<=1.
//  First rise after IDLE produces no valid; first valid follows the 2nd rise.
//  valid: high exactly one cycle, registered in the same clk edge as the
//   outputs it qualifies.
//  width/period/in_range hold their values until the next valid (and across
//   timeout).
//  Counters never exceed TIMEOUT, so there is no wrap-around.
//  Timeout and edge on the same cycle: the edge wins.
//  Glitch shorter than 1 clk may be missed; any pulse seen by s2 is measured.
//  Reset mid-measurement: partial data discarded; FSM=IDLE, outputs to reset values.
// TESTING
//  1. Reset with pwm_in=1 held, then PWM H=230000, P=2000000 -> no valid until
//     the 2nd rise after the line first rises; thereafter valid every 2000000
//     cycles with width=230000, period=2000000, in_range=1.
//  2. H=10, P=25 (params MIN_W=5, MAX_W=12, TIMEOUT=100) -> width=10, period=25,
//     in_range=1 on each valid. Then H=13 -> in_range=0. Then H=5 -> in_range=1.
//  3. Hold pwm_in low after a valid (TIMEOUT=100) -> timeout=1 and active=0
//     exactly 100 cycles after the last rise; width/period unchanged. Resume
//     PWM -> timeout clears on the first new valid.
//  4. Hold pwm_in high for 150 cycles (TIMEOUT=100) -> timeout=1, FSM=IDLE,
//     no valid produced by the following fall.
//  5. Assert reset for 1 cycle mid-HIGH -> all outputs 0 next cycle; the next
//     valid appears only after two further rises.
//  6. Loop back the servo PWM generator (T=2000, D=230) into pwm_in -> captured
//     width/period match the generator's actual output over >=10 periods.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous
// PWM line in clk cycles. One width/period pair is published per complete
// cycle, with a range check on the high time and a sticky dead-line timeout.
//
//  state | meaning
//  IDLE  | no measurement running; waiting for a rising edge
//  HIGH  | line high; cnt counts the high time since the last rise
//  LOW   | line low; cnt keeps counting toward the next rise (period)
module pwm_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4000000,
    parameter int MIN_W   = 50000,
    parameter int MAX_W   = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             in_range,
    output logic             timeout,
    output logic             active
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic             s1, s2, prev;
    logic             rise, fall, at_to;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [CNT_W-1:0] hi_lat, hi_lat_nx;
    logic [CNT_W-1:0] width_nx, period_nx;
    logic             valid_nx, in_range_nx, timeout_nx;

    // Synchronizer and edge history; preset high so a line already high at
    // reset release does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise  = s2 & ~prev;
    assign fall  = ~s2 & prev;
    assign at_to = (cnt >= TO_C);
    // Saturate so the counter can never wrap, even if an edge beats the timeout.
    assign cnt_inc = at_to ? cnt : cnt + ONE;
    assign active  = (state == HIGH) || (state == LOW);

    // State, counter and published results register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_lat   <= '0;
            width    <= '0;
            period   <= '0;
            valid    <= 1'b0;
            in_range <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            hi_lat   <= hi_lat_nx;
            width    <= width_nx;
            period   <= period_nx;
            valid    <= valid_nx;
            in_range <= in_range_nx;
            timeout  <= timeout_nx;
        end
    end

    // Next-state and measurement logic; an edge always takes priority over timeout.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hi_lat_nx   = hi_lat;
        width_nx    = width;
        period_nx   = period;
        valid_nx    = 1'b0;
        in_range_nx = in_range;
        timeout_nx  = timeout;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rise) begin
                    state_nx = HIGH;
                    cnt_nx   = ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_lat_nx = cnt;
                    cnt_nx    = cnt_inc;
                    state_nx  = LOW;
                end else if (at_to) begin
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    width_nx    = hi_lat;
                    period_nx   = cnt;
                    in_range_nx = (hi_lat >= MIN_C) && (hi_lat <= MAX_C);
                    valid_nx    = 1'b1;
                    timeout_nx  = 1'b0;
                    cnt_nx      = ONE;
                    state_nx    = HIGH;
                end else if (at_to) begin
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with small timing parameters.
module tb_pwm_capture;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;
    localparam int MIN_W   = 5;
    localparam int MAX_W   = 12;
    localparam int GEN_T   = 40;
    localparam int GEN_D   = 9;

    typedef struct {
        int   w;
        int   p;
        logic r;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_in;
    logic [CNT_W-1:0] width, period;
    logic             valid, in_range, timeout, active;

    logic pwm_drv = 1'b1;
    logic use_gen = 1'b0;
    logic gen_out = 1'b0;
    int   gen_cnt = 0;
    int   gen_rises = 0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    logic line = 1'b1;
    logic armed = 1'b0;
    int   last_h = 0;
    int   last_p = 0;
    int   v0;

    assign pwm_in = use_gen ? gen_out : pwm_drv;

    pwm_capture #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_W(MIN_W), .MAX_W(MAX_W)
    ) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in),
        .width(width), .period(period), .valid(valid),
        .in_range(in_range), .timeout(timeout), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, longint obs, longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void push_exp(int h, int p);
        exp_t e;
        e.w = h;
        e.p = p;
        e.r = (h >= MIN_W) && (h <= MAX_W);
        sb.push_back(e);
    endfunction

    task automatic drive_level(logic v, int n);
        pwm_drv = v;
        line    = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PWM period starting with a rise; a rise publishes the previous period.
    task automatic pwm_cycle(int h, int p);
        if (!line) begin
            if (armed) push_exp(last_h, last_p);
            armed  = 1'b1;
            last_h = h;
            last_p = p;
        end
        drive_level(1'b1, h);
        drive_level(1'b0, p - h);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_width"}, width, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_in_range"}, in_range, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_active"}, active, 0);
    endtask

    // Loopback PWM generator: registered output, high GEN_D of every GEN_T cycles.
    always @(posedge clk) begin
        if (!use_gen) begin
            gen_cnt   <= 0;
            gen_out   <= 1'b0;
            gen_rises = 0;
        end else begin
            gen_cnt <= (gen_cnt == GEN_T - 1) ? 0 : gen_cnt + 1;
            gen_out <= (gen_cnt < GEN_D);
            if (gen_cnt == 0) begin
                if (gen_rises > 0) push_exp(GEN_D, GEN_T);
                gen_rises = gen_rises + 1;
            end
        end
    end

    // Scoreboard monitor: every valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("valid_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("width", width, mon_e.w);
                check("period", period, mon_e.p);
                check("in_range", in_range, mon_e.r);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Line high at release is not a rise; first rise only arms.
        drive_level(1'b1, 5);
        check("release_high_active", active, 0);
        drive_level(1'b0, 8);
        pwm_cycle(10, 25);
        check("first_rise_no_valid", n_valid, 0);
        check("first_rise_active", active, 1);
        pwm_cycle(10, 25);
        pwm_cycle(10, 25);

        // Range boundaries.
        pwm_cycle(13, 25);
        pwm_cycle(13, 25);
        pwm_cycle(5, 25);
        pwm_cycle(12, 25);
        pwm_cycle(4, 25);
        pwm_cycle(10, 25);

        // Dead line while low: timeout exactly TIMEOUT cycles after the rise acts.
        pwm_cycle(8, 20);
        drive_level(1'b0, 82);
        check("to_low_early_timeout", timeout, 0);
        check("to_low_early_active", active, 1);
        drive_level(1'b0, 1);
        check("to_low_timeout", timeout, 1);
        check("to_low_active", active, 0);
        check("to_low_width_held", width, 10);
        check("to_low_period_held", period, 25);
        armed = 1'b0;
        pwm_cycle(10, 25);
        check("to_held_until_valid", timeout, 1);
        pwm_cycle(10, 25);
        check("to_cleared_by_valid", timeout, 0);

        // Dead line while high; the later fall publishes nothing.
        if (armed) push_exp(last_h, last_p);
        drive_level(1'b1, 150);
        armed = 1'b0;
        check("to_high_timeout", timeout, 1);
        check("to_high_active", active, 0);
        v0 = n_valid;
        drive_level(1'b0, 20);
        check("to_high_fall_no_valid", n_valid, v0);
        check("to_high_still_timeout", timeout, 1);

        // Reset in the middle of a high phase.
        pwm_cycle(10, 25);
        pwm_cycle(10, 25);
        if (armed) push_exp(last_h, last_p);
        drive_level(1'b1, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("midreset");
        armed = 1'b0;
        v0 = n_valid;
        pwm_cycle(10, 25);
        pwm_cycle(10, 25);
        check("midreset_one_rise_no_valid", n_valid, v0);
        pwm_cycle(10, 25);
        check("midreset_two_rises_valid", n_valid, v0 + 1);

        // Loopback of a generator after letting the line go dead.
        drive_level(1'b0, 120);
        armed = 1'b0;
        check("pre_loop_timeout", timeout, 1);
        v0 = n_valid;
        use_gen = 1'b1;
        repeat (12 * GEN_T + 10) @(posedge clk);
        #1;
        use_gen = 1'b0;
        check("loop_valid_count", n_valid - v0, 12);
        check("loop_timeout_cleared", timeout, 0);
        drive_level(1'b0, 120);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
